// File: rtl/tag_alloc_pkg.sv
// Shared definitions for the tag allocator: default tag width and derived pool types.
package tag_alloc_pkg;

  localparam int DEFAULT_TAG_WIDTH = 4;
  localparam int DEFAULT_NUM_TAGS  = 1 << DEFAULT_TAG_WIDTH;

  typedef logic [DEFAULT_TAG_WIDTH-1:0] tag_t;
  typedef logic [DEFAULT_TAG_WIDTH:0]   count_t;

endpackage

// File: rtl/decode.sv
// Binary index to one-hot decoder.
module decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]      idx,
  output logic [(1<<WIDTH)-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < (1 << WIDTH); gi++) begin : g_bit
      assign onehot[gi] = (idx == WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/tag_alloc_pick.sv
// tag_pick: first set bit of free_vec at or after start, wrapping around the pool.
module tag_pick
  import tag_alloc_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) (
  input  logic [(1<<TAG_WIDTH)-1:0] free_vec,
  input  logic [TAG_WIDTH-1:0]      start,
  output logic                      found,
  output logic [TAG_WIDTH-1:0]      idx
);

  localparam int NUM_TAGS = 1 << TAG_WIDTH;

  logic [TAG_WIDTH-1:0] cand;

  // Candidate index wraps naturally through TAG_WIDTH-bit addition.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      cand = start + TAG_WIDTH'(i);
      if (!found && free_vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tag_alloc.sv
// Tag pool allocator: one grant and one release per cycle, single-cycle flush.
// Optional macro TAG_ALLOC_ROUND_ROBIN_EN selects round-robin tag choice.
module tag_alloc
  import tag_alloc_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_req,
  output logic                      alloc_avail,
  output logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic                      rel_valid,
  input  logic [TAG_WIDTH-1:0]      rel_tag,
  input  logic                      flush,
  output logic [(1<<TAG_WIDTH)-1:0] busy_vec,
  output logic [TAG_WIDTH:0]        free_count,
  output logic                      rel_err
);

  localparam int NUM_TAGS = 1 << TAG_WIDTH;

  logic [NUM_TAGS-1:0]  busy_reg, busy_next;
  logic [TAG_WIDTH:0]   free_count_reg, free_count_next;
  logic                 rel_err_reg, rel_err_next;
  logic [NUM_TAGS-1:0]  rel_onehot, grant_onehot;
  logic [TAG_WIDTH-1:0] pick_start;
  logic                 grant, rel_hit, rel_miss;

`ifdef TAG_ALLOC_ROUND_ROBIN_EN
  logic [TAG_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  assign pick_start = rr_ptr_reg;
`else
  assign pick_start = '0;
`endif

  tag_pick #(.TAG_WIDTH(TAG_WIDTH)) u_pick (
    .free_vec (~busy_reg),
    .start    (pick_start),
    .found    (alloc_avail),
    .idx      (alloc_tag)
  );

  decode #(.WIDTH(TAG_WIDTH)) u_rel_dec (
    .idx    (rel_tag),
    .onehot (rel_onehot)
  );

  decode #(.WIDTH(TAG_WIDTH)) u_grant_dec (
    .idx    (alloc_tag),
    .onehot (grant_onehot)
  );

  assign grant    = alloc_req && alloc_avail && !flush;
  assign rel_hit  = rel_valid && busy_reg[rel_tag];
  assign rel_miss = rel_valid && !busy_reg[rel_tag];

  // A granted tag is always free and a released tag always busy, so the two masks never overlap.
  always_comb begin
    busy_next       = busy_reg;
    free_count_next = free_count_reg;
    rel_err_next    = rel_err_reg;
    if (flush) begin
      busy_next       = '0;
      free_count_next = (TAG_WIDTH+1)'(NUM_TAGS);
    end else begin
      if (rel_hit)
        busy_next = busy_next & ~rel_onehot;
      if (grant)
        busy_next = busy_next | grant_onehot;
      free_count_next = free_count_reg - (TAG_WIDTH+1)'(grant) + (TAG_WIDTH+1)'(rel_hit);
      if (rel_miss)
        rel_err_next = 1'b1;
    end
  end

`ifdef TAG_ALLOC_ROUND_ROBIN_EN
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flush)
      rr_ptr_next = '0;
    else if (grant)
      rr_ptr_next = alloc_tag + TAG_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr_reg <= '0;
    else
      rr_ptr_reg <= rr_ptr_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg       <= '0;
      free_count_reg <= (TAG_WIDTH+1)'(NUM_TAGS);
      rel_err_reg    <= 1'b0;
    end else begin
      busy_reg       <= busy_next;
      free_count_reg <= free_count_next;
      rel_err_reg    <= rel_err_next;
    end
  end

  assign busy_vec   = busy_reg;
  assign free_count = free_count_reg;
  assign rel_err    = rel_err_reg;

  count_matches_busy: assert property (@(posedge clk) disable iff (!rst_n)
    int'(free_count_reg) == NUM_TAGS - $countones(busy_reg));

endmodule

// File: tb/tb_tag_alloc.sv
// Directed scoreboard bench for tag_alloc with a 4-entry pool.
module tb_tag_alloc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_avail;
  logic [1:0] alloc_tag;
  logic       rel_valid = 1'b0;
  logic [1:0] rel_tag = 2'd0;
  logic       flush = 1'b0;
  logic [3:0] busy_vec;
  logic [2:0] free_count;
  logic       rel_err;

  int checks = 0;
  int errors = 0;

`ifdef TAG_ALLOC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [3:0] busy;
    logic [2:0] cnt;
    logic       err;
    logic       avail;
    logic [1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  tag_alloc #(.TAG_WIDTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_avail (alloc_avail),
    .alloc_tag   (alloc_tag),
    .rel_valid   (rel_valid),
    .rel_tag     (rel_tag),
    .flush       (flush),
    .busy_vec    (busy_vec),
    .free_count  (free_count),
    .rel_err     (rel_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the state expected after that edge.
  task automatic step(input string nm, input logic rn, input logic req, input logic rv,
                      input logic [1:0] rt, input logic fl, input logic [3:0] eb,
                      input logic [2:0] ec, input logic ee, input logic ea, input logic [1:0] et);
    exp_t e;
    @(negedge clk);
    rst_n = rn; alloc_req = req; rel_valid = rv; rel_tag = rt; flush = fl;
    @(posedge clk);
    e.name = nm; e.busy = eb; e.cnt = ec; e.err = ee; e.avail = ea; e.tag = et;
    exp_q.push_back(e);
  endtask

  // Monitor: compare post-edge state on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (busy_vec !== e.busy || free_count !== e.cnt || rel_err !== e.err ||
          alloc_avail !== e.avail || (e.avail && alloc_tag !== e.tag)) begin
        errors++;
        $display("FAIL %s: got busy=%b cnt=%0d err=%b avail=%b tag=%0d, want busy=%b cnt=%0d err=%b avail=%b tag=%0d",
                 e.name, busy_vec, free_count, rel_err, alloc_avail, alloc_tag,
                 e.busy, e.cnt, e.err, e.avail, e.tag);
      end else begin
        $display("ok   %s: busy=%b cnt=%0d err=%b avail=%b tag=%0d",
                 e.name, busy_vec, free_count, rel_err, alloc_avail, alloc_tag);
      end
    end
  end

  initial begin
    //    name              rn req rv rt fl  busy    cnt err av tag
    step("reset",           0, 0, 0, 0, 0, 4'b0000, 4, 0, 1, 0);
    step("grant0",          1, 1, 0, 0, 0, 4'b0001, 3, 0, 1, 1);
    step("grant1",          1, 1, 0, 0, 0, 4'b0011, 2, 0, 1, 2);
    step("grant2",          1, 1, 0, 0, 0, 4'b0111, 1, 0, 1, 3);
    step("grant3_full",     1, 1, 0, 0, 0, 4'b1111, 0, 0, 0, 0);
    step("req_when_full",   1, 1, 0, 0, 0, 4'b1111, 0, 0, 0, 0);
    step("full_rel2_nobyp", 1, 1, 1, 2, 0, 4'b1011, 1, 0, 1, 2);
    step("regrant2",        1, 1, 0, 0, 0, 4'b1111, 0, 0, 0, 0);
    step("flush_clear",     1, 0, 0, 0, 1, 4'b0000, 4, 0, 1, 0);
    step("grant0_b",        1, 1, 0, 0, 0, 4'b0001, 3, 0, 1, 1);
    step("grant1_b",        1, 1, 0, 0, 0, 4'b0011, 2, 0, 1, 2);
    step("alloc_rel_same",  1, 1, 1, 0, 0, 4'b0110, 2, 0, 1, RR ? 2'd3 : 2'd0);
    step("flush_idle",      1, 0, 0, 0, 1, 4'b0000, 4, 0, 1, 0);
    step("grant0_c",        1, 1, 0, 0, 0, 4'b0001, 3, 0, 1, 1);
    step("bad_release3",    1, 0, 1, 3, 0, 4'b0001, 3, 1, 1, 1);
    step("err_sticky",      1, 0, 0, 0, 0, 4'b0001, 3, 1, 1, 1);
    step("grant1_c",        1, 1, 0, 0, 0, 4'b0011, 2, 1, 1, 2);
    step("grant2_c",        1, 1, 0, 0, 0, 4'b0111, 1, 1, 1, 3);
    step("grant3_c",        1, 1, 0, 0, 0, 4'b1111, 0, 1, 0, 0);
    step("rel1",            1, 0, 1, 1, 0, 4'b1101, 1, 1, 1, 1);
    step("flush_override",  1, 1, 1, 0, 1, 4'b0000, 4, 1, 1, 0);
`ifdef TAG_ALLOC_ROUND_ROBIN_EN
    step("rr_grant0",       1, 1, 0, 0, 0, 4'b0001, 3, 1, 1, 1);
    step("rr_rel0",         1, 0, 1, 0, 0, 4'b0000, 4, 1, 1, 1);
    step("rr_grant1",       1, 1, 0, 0, 0, 4'b0010, 3, 1, 1, 2);
    step("rr_grant2",       1, 1, 0, 0, 0, 4'b0110, 2, 1, 1, 3);
    step("rr_grant3_wrap",  1, 1, 0, 0, 0, 4'b1110, 1, 1, 1, 0);
    step("rr_grant0_wrap",  1, 1, 0, 0, 0, 4'b1111, 0, 1, 0, 0);
`else
    step("grant0_d",        1, 1, 0, 0, 0, 4'b0001, 3, 1, 1, 1);
    step("rel0_d",          1, 0, 1, 0, 0, 4'b0000, 4, 1, 1, 0);
    step("regrant0_d",      1, 1, 0, 0, 0, 4'b0001, 3, 1, 1, 1);
`endif
    step("reset_midop",     0, 1, 1, 0, 0, 4'b0000, 4, 0, 1, 0);
    step("after_reset",     1, 1, 0, 0, 0, 4'b0001, 3, 0, 1, 1);
    @(negedge clk);
    alloc_req = 1'b0; rel_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
